tm_stats_ctrl: RTL and testbench

TM_STATS_CTRL -- requirements
Module: tm_stats_ctrl

---
 rtl/tm_stats_ctrl_if.sv | 13 +
 rtl/tm_stats_ctrl.sv | 144 ++++++++++++++
 tb/tb_tm_stats_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tm_stats_ctrl_if.sv
// tm_stats_ctrl_if: operand/result bus between the transaction statistics
// controller (master) and the tm_alu datapath (slave).
interface tm_stats_ctrl_if;
   logic [7:0] atl;      // AvgTxLen operand
   logic [7:0] ie;       // InstExed operand
   logic [7:0] ctl;      // CurTxLen operand
   logic       alu_req;  // one-cycle operand-valid strobe
   logic [7:0] atln;     // ALU result: new AvgTxLen
   logic [7:0] ien;      // ALU result: new InstExed

   modport master (output atl, ie, ctl, alu_req, input atln, ien);
   modport slave  (input atl, ie, ctl, alu_req, output atln, ien);
endinterface

// File: rtl/tm_stats_ctrl.sv
// tm_stats_ctrl: counts instructions inside a transaction, hands the length
// plus the stored statistics to tm_alu on commit, and captures the ALU's
// updated statistics ALU_LAT cycles later. Aborts are counted separately.
module tm_stats_ctrl #(
   parameter int ALU_LAT = 1   // 1..4 cycles from alu_req to valid atln/ien
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tx_begin,
   input  logic            inst_valid,
   input  logic            tx_end,
   input  logic            tx_abort,
   tm_stats_ctrl_if.master alu,
   output logic            busy,
   output logic            upd_done,
   output logic [7:0]      abort_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_IN_TX   = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;

   // Last value of the WAIT counter before moving to CAPTURE (WAIT lasts
   // ALU_LAT-1 cycles; unused when ALU_LAT is 1 because WAIT is skipped).
   localparam logic [1:0] WAIT_LAST = (ALU_LAT > 1) ? 2'(ALU_LAT - 2) : 2'd0;

   logic [2:0] state_q,     state_d;
   logic [1:0] wait_cnt_q,  wait_cnt_d;
   logic [7:0] cur_len_q,   cur_len_d;
   logic [7:0] stat_avg_q,  stat_avg_d;
   logic [7:0] stat_ie_q,   stat_ie_d;
   logic [7:0] atl_q,       atl_d;
   logic [7:0] ie_q,        ie_d;
   logic [7:0] ctl_q,       ctl_d;
   logic [7:0] abort_cnt_q, abort_cnt_d;

   logic [7:0] len_inc;
   logic [7:0] len_final;

   // Transaction length including this cycle's retired instruction, saturating.
   always_comb begin
      len_inc   = (cur_len_q == 8'hFF) ? cur_len_q : cur_len_q + 8'd1;
      len_final = inst_valid ? len_inc : cur_len_q;
   end

   // Next-state and datapath update for the controller FSM.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      cur_len_d   = cur_len_q;
      stat_avg_d  = stat_avg_q;
      stat_ie_d   = stat_ie_q;
      atl_d       = atl_q;
      ie_d        = ie_q;
      ctl_d       = ctl_q;
      abort_cnt_d = abort_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (tx_begin) begin
               state_d   = S_IN_TX;
               cur_len_d = 8'd0;
            end
         end
         S_IN_TX: begin
            if (tx_abort) begin
               // Abort wins over a same-cycle commit; the length is dropped.
               state_d     = S_IDLE;
               cur_len_d   = 8'd0;
               abort_cnt_d = (abort_cnt_q == 8'hFF) ? abort_cnt_q
                                                    : abort_cnt_q + 8'd1;
            end else if (tx_end) begin
               cur_len_d = len_final;
               if (len_final == 8'd0) begin
                  // Empty transaction: nothing worth averaging in.
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ISSUE;
                  atl_d   = stat_avg_q;
                  ie_d    = stat_ie_q;
                  ctl_d   = len_final;
               end
            end else begin
               cur_len_d = len_final;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = 2'd0;
            state_d    = (ALU_LAT > 1) ? S_WAIT : S_CAPTURE;
         end
         S_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_CAPTURE;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         S_CAPTURE: begin
            stat_avg_d = alu.atln;
            stat_ie_d  = alu.ien;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight ALU request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= 2'd0;
         cur_len_q   <= 8'd0;
         stat_avg_q  <= 8'd0;
         stat_ie_q   <= 8'd0;
         atl_q       <= 8'd0;
         ie_q        <= 8'd0;
         ctl_q       <= 8'd0;
         abort_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         cur_len_q   <= cur_len_d;
         stat_avg_q  <= stat_avg_d;
         stat_ie_q   <= stat_ie_d;
         atl_q       <= atl_d;
         ie_q        <= ie_d;
         ctl_q       <= ctl_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   // Operands stay in their registers from ISSUE until the next commit.
   assign alu.atl     = atl_q;
   assign alu.ie      = ie_q;
   assign alu.ctl     = ctl_q;
   assign alu.alu_req = (state_q == S_ISSUE);
   assign upd_done    = (state_q == S_CAPTURE);
   assign busy        = (state_q != S_IDLE) && (state_q != S_IN_TX);
   assign abort_cnt   = abort_cnt_q;

endmodule

// File: tb/tb_tm_stats_ctrl.sv
// tb_tm_stats_ctrl: directed and randomized transactions against a
// transaction-level model of the statistics controller, with an ALU stub
// whose results are only valid in the single cycle the DUT must capture them.
module tb_tm_stats_ctrl;
   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_begin, inst_valid, tx_end, tx_abort;
   logic       busy, upd_done;
   logic [7:0] abort_cnt;

   tm_stats_ctrl_if alu_if ();

   tm_stats_ctrl #(.ALU_LAT(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_begin   (tx_begin),
      .inst_valid (inst_valid),
      .tx_end     (tx_end),
      .tx_abort   (tx_abort),
      .alu        (alu_if.master),
      .busy       (busy),
      .upd_done   (upd_done),
      .abort_cnt  (abort_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Transaction-level model: stored statistics are whatever the ALU last
   // returned for a committed non-empty transaction; aborts counted, capped.
   int m_avg   = 0;
   int m_ie    = 0;
   int m_abort = 0;

   // ALU stub: results valid exactly LAT cycles after alu_req, inverted otherwise.
   logic [7:0] stub_atln = 8'd0;
   logic [7:0] stub_ien  = 8'd0;
   int         stub_cnt  = 0;
   always @(posedge clk) begin
      if (reset)                 stub_cnt <= 0;
      else if (alu_if.alu_req)   stub_cnt <= LAT;
      else if (stub_cnt > 0)     stub_cnt <= stub_cnt - 1;
   end
   assign alu_if.atln = (stub_cnt == 1) ? stub_atln : ~stub_atln;
   assign alu_if.ien  = (stub_cnt == 1) ? stub_ien  : ~stub_ien;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Strobe invariants: never together, never two cycles in a row.
   logic prev_req = 1'b0;
   logic prev_upd = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         chk("req_upd_overlap", 32'(alu_if.alu_req && upd_done), 0);
         chk("strobe_repeat", 32'((prev_req && alu_if.alu_req) || (prev_upd && upd_done)), 0);
      end
      prev_req <= alu_if.alu_req;
      prev_upd <= upd_done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      tx_begin = 1'b0; inst_valid = 1'b0; tx_end = 1'b0; tx_abort = 1'b0;
   endtask

   // kind: 0 commit, 1 abort, 2 commit+abort together.
   task automatic run_tx(input int n, input int kind, input bit last_inst,
                         input bit gaps, input bit noise, input int r_atl, input int r_ie);
      int len;
      stub_atln = 8'(r_atl);
      stub_ien  = 8'(r_ie);
      tx_begin = 1'b1; tick(); tx_begin = 1'b0;
      len = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            inst_valid = 1'b0; tx_begin = 1'b1; tick(); tx_begin = 1'b0;
         end
         inst_valid = 1'b1; tick(); len++;
      end
      inst_valid = last_inst;
      if (kind == 0)      tx_end = 1'b1;
      else if (kind == 1) tx_abort = 1'b1;
      else begin tx_end = 1'b1; tx_abort = 1'b1; end
      if (kind == 0 && last_inst) len++;
      tick(); clear_in();
      if (len > 255) len = 255;
      if (kind != 0) begin
         if (m_abort < 255) m_abort++;
         chk("abort_no_req", 32'(alu_if.alu_req), 0);
         chk("abort_busy", 32'(busy), 0);
         chk("abort_cnt", 32'(abort_cnt), m_abort);
         tick();
         chk("abort_no_upd", 32'(upd_done), 0);
      end else if (len == 0) begin
         chk("zero_no_req", 32'(alu_if.alu_req), 0);
         chk("zero_busy", 32'(busy), 0);
         tick();
         chk("zero_no_upd", 32'(upd_done), 0);
         chk("zero_no_req2", 32'(alu_if.alu_req), 0);
      end else begin
         chk("issue_req", 32'(alu_if.alu_req), 1);
         chk("issue_ctl", 32'(alu_if.ctl), len);
         chk("issue_atl", 32'(alu_if.atl), m_avg);
         chk("issue_ie", 32'(alu_if.ie), m_ie);
         chk("issue_busy", 32'(busy), 1);
         for (int c = 1; c <= LAT; c++) begin
            if (noise) begin
               tx_begin   = 1'($urandom);
               inst_valid = 1'($urandom);
               tx_end     = 1'($urandom);
               tx_abort   = 1'($urandom);
            end
            tick();
            chk("upd_timing", 32'(upd_done), (c == LAT) ? 1 : 0);
         end
         clear_in();
         chk("hold_ctl", 32'(alu_if.ctl), len);
         chk("hold_atl", 32'(alu_if.atl), m_avg);
         chk("hold_ie", 32'(alu_if.ie), m_ie);
         chk("cap_busy", 32'(busy), 1);
         m_avg = r_atl & 255;
         m_ie  = r_ie & 255;
         tick();
         chk("post_busy", 32'(busy), 0);
         chk("post_upd", 32'(upd_done), 0);
         chk("post_abort_cnt", 32'(abort_cnt), m_abort);
      end
      $display("tx n=%0d kind=%0d last=%0b noise=%0b len=%0d avg=%0d ie=%0d aborts=%0d",
               n, kind, last_inst, noise, len, m_avg, m_ie, m_abort);
   endtask

   initial begin
      clear_in();
      reset = 1'b1;
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_upd", 32'(upd_done), 0);
      chk("rst_req", 32'(alu_if.alu_req), 0);
      chk("rst_atl", 32'(alu_if.atl), 0);
      chk("rst_ie", 32'(alu_if.ie), 0);
      chk("rst_ctl", 32'(alu_if.ctl), 0);
      chk("rst_abort", 32'(abort_cnt), 0);
      reset = 1'b0;

      // Nominal path, starting the very next cycle after reset release.
      run_tx(5, 0, 1'b0, 1'b0, 1'b0, 10, 3);
      run_tx(2, 0, 1'b0, 1'b0, 1'b0, 20, 7);
      // Same-cycle inst_valid with tx_end, then tx_end together with tx_abort.
      run_tx(2, 0, 1'b1, 1'b0, 1'b0, 30, 9);
      run_tx(4, 2, 1'b1, 1'b0, 1'b0, 0, 0);
      // Zero-length commit leaves statistics alone.
      run_tx(0, 0, 1'b0, 1'b0, 1'b0, 99, 99);
      run_tx(1, 0, 1'b0, 1'b1, 1'b0, 40, 11);
      // Inputs wiggled while busy are ignored; next length starts from 0.
      run_tx(3, 0, 1'b0, 1'b0, 1'b1, 50, 12);
      run_tx(2, 0, 1'b0, 1'b0, 1'b0, 60, 13);
      // Length saturation.
      run_tx(300, 0, 1'b0, 1'b1, 1'b0, 70, 14);
      // Abort counter saturation.
      for (int i = 0; i < 260; i++) run_tx(0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("abort_sat", 32'(abort_cnt), 255);
      // Randomized mix.
      for (int i = 0; i < 30; i++) begin
         int k;
         k = $urandom_range(0, 3);
         run_tx($urandom_range(0, 12), (k < 2) ? 0 : k - 1, 1'($urandom),
                1'($urandom), 1'($urandom),
                $urandom_range(0, 255), $urandom_range(0, 255));
      end

      // Reset one cycle after alu_req, in the middle of WAIT.
      stub_atln = 8'h55; stub_ien = 8'h66;
      tx_begin = 1'b1; tick(); tx_begin = 1'b0;
      inst_valid = 1'b1; repeat (4) tick(); inst_valid = 1'b0;
      tx_end = 1'b1; tick(); tx_end = 1'b0;
      chk("midwait_req", 32'(alu_if.alu_req), 1);
      tick();
      #2 reset = 1'b1;
      #1;
      chk("midwait_busy", 32'(busy), 0);
      chk("midwait_atl", 32'(alu_if.atl), 0);
      chk("midwait_ie", 32'(alu_if.ie), 0);
      chk("midwait_ctl", 32'(alu_if.ctl), 0);
      chk("midwait_abort", 32'(abort_cnt), 0);
      chk("midwait_upd", 32'(upd_done), 0);
      m_avg = 0; m_ie = 0; m_abort = 0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
         tick();
         chk("midwait_no_upd", 32'(upd_done), 0);
      end
      $display("reset mid-WAIT applied, stats cleared");
      run_tx(2, 0, 1'b0, 1'b0, 1'b0, 5, 6);
      run_tx(1, 0, 1'b1, 1'b0, 1'b0, 7, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
